// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller oversampled on iclk: synchronizes tck/tms/tdi, runs the 16-state FSM,
// drives IR/DR cell strobes and muxes tdo. Optional JTAG test reset pin enabled by DP_TAP_TRST_EN.
module dp_tap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iclk,
  input  logic       reset,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
`ifdef DP_TAP_TRST_EN
  input  logic       trst_n,
`endif
  output logic       tdi_s,
  input  logic       tdo_ir_in,
  input  logic       tdo_dr_in,
  output logic       tdo,
  output logic       tdo_oe,
  output logic       shift_ir,
  output logic       clk_ir,
  output logic       update_ir,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic       tlr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e state_q, state_next;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic tck_s, tck_d, tms_s, tck_rise, tck_fall, fsm_rst;

  // tck chain and edge flop reset high so a pin already high after reset is not seen as a rise.
  always_ff @(posedge iclk) begin
    if (reset) begin
      tck_sync <= '1;
      tck_d    <= 1'b1;
      tms_sync <= '0;
      tdi_sync <= '0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tck_d    <= tck_s;
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_d;
  assign tck_fall = ~tck_s & tck_d;

`ifdef DP_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync;

  always_ff @(posedge iclk) begin
    if (reset) trst_sync <= '1;
    else       trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_n};
  end

  assign fsm_rst = reset | ~trst_sync[SYNC_STAGES-1];
`else
  assign fsm_rst = reset;
`endif

  always_comb begin
    state_next = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:    state_next = tms_s ? TLR    : RTI;
        RTI:    state_next = tms_s ? SEL_DR : RTI;
        SEL_DR: state_next = tms_s ? SEL_IR : CAP_DR;
        CAP_DR: state_next = tms_s ? EX1_DR : SH_DR;
        SH_DR:  state_next = tms_s ? EX1_DR : SH_DR;
        EX1_DR: state_next = tms_s ? UPD_DR : PA_DR;
        PA_DR:  state_next = tms_s ? EX2_DR : PA_DR;
        EX2_DR: state_next = tms_s ? UPD_DR : SH_DR;
        UPD_DR: state_next = tms_s ? SEL_DR : RTI;
        SEL_IR: state_next = tms_s ? TLR    : CAP_IR;
        CAP_IR: state_next = tms_s ? EX1_IR : SH_IR;
        SH_IR:  state_next = tms_s ? EX1_IR : SH_IR;
        EX1_IR: state_next = tms_s ? UPD_IR : PA_IR;
        PA_IR:  state_next = tms_s ? EX2_IR : PA_IR;
        EX2_IR: state_next = tms_s ? UPD_IR : SH_IR;
        UPD_IR: state_next = tms_s ? SEL_DR : RTI;
        default: state_next = TLR;
      endcase
    end
  end

  // Strobes are judged on the state being left, so capture sees shift_* low (parallel input).
  always_ff @(posedge iclk) begin
    if (fsm_rst) begin
      state_q   <= TLR;
      clk_ir    <= 1'b0;
      clk_dr    <= 1'b0;
      shift_ir  <= 1'b0;
      shift_dr  <= 1'b0;
      update_ir <= 1'b0;
      update_dr <= 1'b0;
      tdo       <= 1'b0;
      tdo_oe    <= 1'b0;
    end else begin
      state_q   <= state_next;
      clk_ir    <= tck_rise && (state_q == CAP_IR || state_q == SH_IR);
      clk_dr    <= tck_rise && (state_q == CAP_DR || state_q == SH_DR);
      update_ir <= tck_fall && (state_q == UPD_IR);
      update_dr <= tck_fall && (state_q == UPD_DR);
      if (tck_rise) begin
        shift_ir <= (state_q == SH_IR);
        shift_dr <= (state_q == SH_DR);
      end
      if (tck_fall) begin
        tdo    <= (state_q == SH_IR) ? tdo_ir_in : tdo_dr_in;
        tdo_oe <= (state_q == SH_IR) || (state_q == SH_DR);
      end
    end
  end

  assign tlr   = (state_q == TLR);
  assign state = state_q;

endmodule
